// File: rtl/uut_alu_pipe_if.sv
// Valid/ready bus for the two-stage ALU pipeline.
// The master side drives operations and accepts results; the slave side is the ALU.
interface uut_alu_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, zero, carry
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, zero, carry
   );
endinterface

// File: rtl/uut_alu_pipe.sv
// Two-stage valid/ready ALU pipeline.
// S1 captures the operands and opcode; S2 holds the computed result, zero and carry flags.
module uut_alu_pipe #(
   parameter int WIDTH = 8
) (
   input logic          clock,
   input logic          reset,
   uut_alu_pipe_if.slave bus
);

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_SHL  = 3'b101,
      OP_SHR  = 3'b110,
      OP_PASS = 3'b111
   } op_e;

   localparam logic [WIDTH:0] WIDTH_V = (WIDTH+1)'(WIDTH);

   // Stage 1 state
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] a_q, b_q;
   op_e              op_q;

   // Stage 2 state
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] result_q;
   logic             zero_q, carry_q;

   // Handshake and datapath nets
   logic             s2_load, s2_fire, in_fire, in_ready_w;
   logic [WIDTH-1:0] alu_res;
   logic             alu_zero, alu_carry;
   logic [WIDTH:0]   sum, diff;
   logic             shift_oob;

   // Stage occupancy: S1 may refill in the same cycle it hands over to S2,
   // which is what lets a full pipe accept and emit without a bubble.
   always_comb begin
      s2_load    = s1_valid_q && (!s2_valid_q || bus.out_ready);
      s2_fire    = s2_valid_q && bus.out_ready;
      in_ready_w = !reset && (!s1_valid_q || s2_load);
      in_fire    = bus.in_valid && in_ready_w;

      s1_valid_d = s1_valid_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end

      s2_valid_d = s2_valid_q;
      if (s2_load) begin
         s2_valid_d = 1'b1;
      end else if (s2_fire) begin
         s2_valid_d = 1'b0;
      end
   end

   // ALU evaluated on the S1 contents; carry is the add carry-out or the subtract borrow.
   always_comb begin
      sum       = {1'b0, a_q} + {1'b0, b_q};
      diff      = {1'b0, a_q} - {1'b0, b_q};
      shift_oob = ({1'b0, b_q} >= WIDTH_V);
      alu_res   = '0;
      alu_carry = 1'b0;
      unique case (op_q)
         OP_ADD: begin
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
         end
         OP_SUB: begin
            alu_res   = diff[WIDTH-1:0];
            alu_carry = diff[WIDTH];
         end
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_XOR:  alu_res = a_q ^ b_q;
         OP_SHL:  alu_res = shift_oob ? '0 : (a_q << b_q);
         OP_SHR:  alu_res = shift_oob ? '0 : (a_q >> b_q);
         OP_PASS: alu_res = a_q;
      endcase
      alu_zero = (alu_res == '0);
   end

   // Stage 1 register: operands captured on an input transfer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= OP_ADD;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (in_fire) begin
            a_q  <= bus.a;
            b_q  <= bus.b;
            op_q <= op_e'(bus.op);
         end
      end
   end

   // Stage 2 register: result only updates on a load, so it holds under backpressure.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s2_valid_q <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
      end else begin
         s2_valid_q <= s2_valid_d;
         if (s2_load) begin
            result_q <= alu_res;
            zero_q   <= alu_zero;
            carry_q  <= alu_carry;
         end
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = s2_valid_q;
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_q;

endmodule

// File: doc/uut_alu_pipe.md
UUT_ALU_PIPE -- requirements
Module: uut_alu_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, data width of operands and result.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clock.
REQ-004 in_valid  input  1  upstream presents a valid operation.
REQ-005 in_ready  output  1  block accepts the operation this cycle.
REQ-006 a  input  WIDTH  operand A (the upstream free-running count feeds this port).
REQ-007 b  input  WIDTH  operand B / shift amount.
REQ-008 op  input  3  operation select.
REQ-009 out_valid  output  1  result, zero and carry are valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 result  output  WIDTH  registered result.
REQ-012 zero  output  1  result == 0.
REQ-013 carry  output  1  carry or borrow of the operation.

Function
REQ-014 The block SHALL be a two-stage valid/ready pipeline: S1 registers {a, b, op}; S2 registers {result, zero, carry} computed from S1.
REQ-015 An input transfer SHALL occur when in_valid && in_ready at a rising edge; an output transfer SHALL occur when out_valid && out_ready.
REQ-016 S2 SHALL load when S1 is valid and (S2 is empty or out_ready=1); S2 SHALL go empty when it transfers out and S1 is empty.
REQ-017 in_ready SHALL equal (!S1_valid || S2 loading this cycle); the combinational out_ready-to-in_ready path is permitted.
REQ-018 Minimum latency SHALL be 2 cycles: an op accepted at edge N appears with out_valid=1 after edge N+1.
REQ-019 Sustained throughput SHALL be one op per cycle while out_ready=1; no op SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-020 While out_valid=1 and out_ready=0, result, zero and carry SHALL hold stable.
REQ-021 Op encoding SHALL be: 000 a+b; 001 a-b; 010 a&b; 011 a|b; 100 a^b; 101 a<<b; 110 a>>b (logical); 111 pass a.
REQ-022 Arithmetic SHALL wrap modulo 2^WIDTH.
REQ-023 carry SHALL be bit WIDTH of a+b for op 000, 1 when a<b (borrow) for op 001, and 0 for all other ops.
REQ-024 For shifts with b >= WIDTH, result SHALL be 0.
REQ-025 zero SHALL be 1 exactly when the WIDTH-bit result is 0, for every op.
REQ-026 Accept-and-emit in the same cycle with both stages full SHALL advance both stages with no bubble.

Reset
REQ-027 On reset assertion, S1_valid, out_valid, result, zero and carry SHALL go to 0 asynchronously.
REQ-028 In-flight operations SHALL be discarded on reset; no out_valid pulse SHALL follow reset deassertion until a new op is accepted.
REQ-029 While reset is high, in_ready SHALL be 0.
REQ-030 After reset deassertion, in_ready SHALL be 1 in the first cycle.

Verification
REQ-031 Add with carry: a=8'hF0, b=8'h20, op=000, out_ready=1 -> 2 cycles later result=8'h10, carry=1, zero=0.
REQ-032 Subtract borrow and zero: a=5, b=5, op=001 -> result=0, zero=1, carry=0; then a=3, b=5 -> result=8'hFE, carry=1.
REQ-033 Shift bound: a=8'h81, op=101, b=1 -> 8'h02; b=8 -> 8'h00, zero=1; op=110, b=7 -> 8'h01.
REQ-034 Backpressure: stream 4 ops back-to-back with out_ready=0 -> in_ready drops after 2 accepts and result holds; raise out_ready -> all 4 results emerge in order, none lost or duplicated.
REQ-035 Random in_valid/out_ready (50% each), 1000 ops against a reference model -> results match in order; with constant in_valid=out_ready=1, one result per cycle.
REQ-036 Reset mid-flight: assert reset asynchronously between edges with both stages full -> outputs 0 immediately; after release, out_valid stays 0 until a new op is accepted and has traversed 2 cycles.
